// File: rtl/stopwatch_display_scan_if.sv
// stopwatch_display_scan_if: digit values and mode controls in, display pins out.
// master = counter chain / board side, slave = the scan driver.
interface stopwatch_display_scan_if;
    logic [3:0] sec_ones;
    logic [2:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       adjust;
    logic       sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    modport master (
        output sec_ones, sec_tens, min_ones, min_tens, adjust, sel,
        input  an, seg, dp
    );
    modport slave (
        input  sec_ones, sec_tens, min_ones, min_tens, adjust, sel,
        output an, seg, dp
    );
endinterface

// File: rtl/stopwatch_display_scan.sv
// stopwatch_display_scan: 4-digit common-anode scan driver with per-frame snapshot.
// Define DISPLAY_BLINK_EN to blink the selected digit pair in adjust mode.
module stopwatch_display_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input logic clk,
    input logic reset,
    stopwatch_display_scan_if.slave bus
);
    localparam int RW = $clog2(REFRESH_DIV);
    logic [RW-1:0]   rcnt;
    logic [1:0]      idx;
    logic [3:0][3:0] snap;
    logic [3:0]      digit;
    logic [6:0]      seg_d;
    logic            rwrap;
    logic            blank;
    assign rwrap = rcnt == RW'(REFRESH_DIV - 1);
    // sec_tens 6/7 are folded into an out-of-range code so they decode to a dash
    always_ff @(posedge clk) begin
        if (reset) begin
            rcnt <= '0;
            idx  <= '0;
            snap <= '0;
        end else begin
            rcnt <= rwrap ? '0 : rcnt + RW'(1);
            if (rwrap)
                idx <= idx + 2'd1;
            if (rwrap && idx == 2'd3)
                snap <= {bus.min_tens, bus.min_ones,
                         bus.sec_tens > 3'd5 ? 4'hf : {1'b0, bus.sec_tens}, bus.sec_ones};
        end
    end
    always_comb begin
        digit = snap[idx];
        case (digit)
            4'd0:    seg_d = 7'h40;
            4'd1:    seg_d = 7'h79;
            4'd2:    seg_d = 7'h24;
            4'd3:    seg_d = 7'h30;
            4'd4:    seg_d = 7'h19;
            4'd5:    seg_d = 7'h12;
            4'd6:    seg_d = 7'h02;
            4'd7:    seg_d = 7'h78;
            4'd8:    seg_d = 7'h00;
            4'd9:    seg_d = 7'h10;
            default: seg_d = 7'h3f;
        endcase
    end
`ifdef DISPLAY_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);
    logic [BW-1:0] bcnt;
    logic          phase;
    logic          bwrap;
    assign bwrap = bcnt == BW'(BLINK_DIV - 1);
    // leaving adjust mode clears the blinker so the next entry starts visible
    always_ff @(posedge clk) begin
        if (reset || !bus.adjust) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else begin
            bcnt <= bwrap ? '0 : bcnt + BW'(1);
            if (bwrap)
                phase <= ~phase;
        end
    end
    assign blank = bus.adjust && phase && (bus.sel == idx[1]);
`else
    logic unused_blink;
    assign unused_blink = ^{bus.adjust, bus.sel, BLINK_DIV[0]};
    assign blank = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset || blank) begin
            bus.an  <= 4'hf;
            bus.seg <= 7'h7f;
            bus.dp  <= 1'b1;
        end else begin
            bus.an  <= ~(4'b0001 << idx);
            bus.seg <= seg_d;
            bus.dp  <= idx != 2'd2;
        end
    end
endmodule
